// File: rtl/sirv_regvec_rdport_pkg.sv
// ----------------------------------------------------------------------------
// sirv_regvec_rdport_pkg
// Shared definitions for the register-vector read port:
//   state_t    - burst FSM encoding (IDLE / RESP)
//   LEN_W      - width of the burst length field (beats minus one)
//   slice_off  - bit offset of vector k inside a flattened bank
// ----------------------------------------------------------------------------
package sirv_regvec_rdport_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam int LEN_W = 2;

    // Vector k of a flattened bank lives at bits [k*dw +: dw].
    function automatic int slice_off(input int k, input int dw);
        return k * dw;
    endfunction

endpackage

// File: rtl/sirv_regvec_rdport_if.sv
// ----------------------------------------------------------------------------
// sirv_regvec_rdport_if
// Request and response channels of the register-vector read port.
//   io_req_valid/io_req_ready  request handshake
//   io_req_addr                start index
//   io_req_len                 beats minus one
//   io_rsp_valid/io_rsp_ready  response beat handshake
//   io_rsp_data/err/last       beat payload
// Modports: master = requester (bus adapter), slave = read port.
// ----------------------------------------------------------------------------
interface sirv_regvec_rdport_if #(
    parameter int DW = 5,
    parameter int AW = 3
);
    import sirv_regvec_rdport_pkg::*;

    logic             io_req_valid;
    logic             io_req_ready;
    logic [AW-1:0]    io_req_addr;
    logic [LEN_W-1:0] io_req_len;
    logic             io_rsp_valid;
    logic             io_rsp_ready;
    logic [DW-1:0]    io_rsp_data;
    logic             io_rsp_err;
    logic             io_rsp_last;

    modport master (
        output io_req_valid, io_req_addr, io_req_len, io_rsp_ready,
        input  io_req_ready, io_rsp_valid, io_rsp_data, io_rsp_err, io_rsp_last
    );

    modport slave (
        input  io_req_valid, io_req_addr, io_req_len, io_rsp_ready,
        output io_req_ready, io_rsp_valid, io_rsp_data, io_rsp_err, io_rsp_last
    );

endinterface

// File: rtl/sirv_regvec_rd_mux.sv
// ----------------------------------------------------------------------------
// sirv_regvec_rd_mux
// Combinational select of one DW-bit vector out of a flattened NREG*DW bank.
//   i_bus       flattened bank, vector k at [k*DW +: DW]
//   i_idx       vector index
//   o_data      selected vector, zero when the index is out of range
//   o_in_range  1 when i_idx < NREG
// ----------------------------------------------------------------------------
module sirv_regvec_rd_mux
    import sirv_regvec_rdport_pkg::*;
#(
    parameter int DW   = 5,
    parameter int NREG = 5,
    parameter int AW   = 3
) (
    input  logic [NREG*DW-1:0] i_bus,
    input  logic [AW-1:0]      i_idx,
    output logic [DW-1:0]      o_data,
    output logic               o_in_range
);

    // One extra bit so NREG == 2^AW still compares correctly.
    localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        o_data     = '0;
        o_in_range = ({1'b0, i_idx} < NREG_L);
        for (int k = 0; k < NREG; k++) begin
            if (i_idx == AW'(k)) begin
                o_data = i_bus[slice_off(k, DW) +: DW];
            end
        end
    end

endmodule

// File: rtl/sirv_regvec_rdport.sv
// ----------------------------------------------------------------------------
// sirv_regvec_rdport
// Burst read port for a bank of register vectors. A request (start index,
// beats minus one) is accepted in IDLE; the bank is snapshotted at that edge
// so the whole burst is coherent, then one vector per beat is returned.
// Out-of-range indices still produce a beat with data 0 and err=1; indices
// wrap modulo 2^AW.
//   clock    rising-edge clock
//   reset    synchronous, active-high
//   io_regs  flattened live bank
//   io_port  request/response channels (slave side)
//   io_busy  burst in progress
// ----------------------------------------------------------------------------
module sirv_regvec_rdport
    import sirv_regvec_rdport_pkg::*;
#(
    parameter int DW   = 5,
    parameter int NREG = 5,
    parameter int AW   = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREG*DW-1:0]   io_regs,
    sirv_regvec_rdport_if.slave  io_port,
    output logic                 io_busy
);

    state_t             r_state;
    state_t             w_next;
    logic [NREG*DW-1:0] r_snap;
    logic [AW-1:0]      r_cur_idx;
    logic [LEN_W-1:0]   r_left;
    logic [DW-1:0]      r_rsp_data;
    logic               r_rsp_err;
    logic               r_rsp_last;

    logic [DW-1:0]      w_live_data;
    logic               w_live_in;
    logic [DW-1:0]      w_snap_data;
    logic               w_snap_in;
    logic               w_accept;
    logic               w_beat_done;

    // First beat comes from the live bank (equal to the snapshot being taken
    // at the same edge); later beats come from the snapshot.
    sirv_regvec_rd_mux #(.DW(DW), .NREG(NREG), .AW(AW)) u_live_mux (
        .i_bus      (io_regs),
        .i_idx      (io_port.io_req_addr),
        .o_data     (w_live_data),
        .o_in_range (w_live_in)
    );

    sirv_regvec_rd_mux #(.DW(DW), .NREG(NREG), .AW(AW)) u_snap_mux (
        .i_bus      (r_snap),
        .i_idx      (r_cur_idx),
        .o_data     (w_snap_data),
        .o_in_range (w_snap_in)
    );

    assign w_accept    = (r_state == ST_IDLE) && io_port.io_req_valid;
    assign w_beat_done = (r_state == ST_RESP) && io_port.io_rsp_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (io_port.io_req_valid) w_next = ST_RESP;
            ST_RESP: if (io_port.io_rsp_ready && r_rsp_last) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The snapshot is cleared on reset along with the beat registers, so a
    // fresh port never exposes stale bank contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_snap     <= '0;
            r_cur_idx  <= '0;
            r_left     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_rsp_last <= 1'b0;
        end else if (w_accept) begin
            r_snap     <= io_regs;
            r_cur_idx  <= io_port.io_req_addr + 1'b1;
            r_left     <= io_port.io_req_len;
            r_rsp_data <= w_live_data;
            r_rsp_err  <= ~w_live_in;
            r_rsp_last <= (io_port.io_req_len == '0);
        end else if (w_beat_done && !r_rsp_last) begin
            // r_left counts beats remaining after the one on the bus.
            r_snap     <= r_snap;
            r_cur_idx  <= r_cur_idx + 1'b1;
            r_left     <= r_left - 1'b1;
            r_rsp_data <= w_snap_data;
            r_rsp_err  <= ~w_snap_in;
            r_rsp_last <= (r_left == LEN_W'(1));
        end
    end

    assign io_port.io_req_ready = (r_state == ST_IDLE);
    assign io_port.io_rsp_valid = (r_state == ST_RESP);
    assign io_port.io_rsp_data  = r_rsp_data;
    assign io_port.io_rsp_err   = r_rsp_err;
    assign io_port.io_rsp_last  = r_rsp_last;
    assign io_busy              = (r_state == ST_RESP);

endmodule

// File: tb/tb_sirv_regvec_rdport.sv
// ----------------------------------------------------------------------------
// tb_sirv_regvec_rdport
// Directed bench for the register-vector read port with hand-computed beats.
// ----------------------------------------------------------------------------
module tb_sirv_regvec_rdport;
    import sirv_regvec_rdport_pkg::*;

    localparam int DW   = 5;
    localparam int NREG = 5;
    localparam int AW   = 3;

    logic               clock;
    logic               reset;
    logic [NREG*DW-1:0] regs;
    logic               busy;

    int n_checks;
    int n_errors;
    int n_accepts;

    sirv_regvec_rdport_if #(.DW(DW), .AW(AW)) bus ();

    sirv_regvec_rdport #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
        .clock   (clock),
        .reset   (reset),
        .io_regs (regs),
        .io_port (bus.slave),
        .io_busy (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; count an acceptance if the handshake holds at the edge.
    task automatic tick();
        if (!reset && bus.io_req_valid && bus.io_req_ready) n_accepts++;
        @(posedge clock);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [DW-1:0] d, input logic e, input logic l);
        check({tag, ".valid"}, 32'(bus.io_rsp_valid), 32'd1);
        check({tag, ".data"},  32'(bus.io_rsp_data),  32'(d));
        check({tag, ".err"},   32'(bus.io_rsp_err),   32'(e));
        check({tag, ".last"},  32'(bus.io_rsp_last),  32'(l));
    endtask

    task automatic request(input logic [AW-1:0] addr, input logic [1:0] len);
        bus.io_req_valid = 1'b1;
        bus.io_req_addr  = addr;
        bus.io_req_len   = len;
        tick();
        bus.io_req_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rsp_valid"}, 32'(bus.io_rsp_valid), 32'd0);
        check({tag, ".req_ready"}, 32'(bus.io_req_ready), 32'd1);
        check({tag, ".busy"},      32'(busy),             32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0; n_accepts = 0;
        regs = '0;
        regs[0*DW +: DW] = 5'h11;
        regs[1*DW +: DW] = 5'h03;
        regs[2*DW +: DW] = 5'h15;
        regs[3*DW +: DW] = 5'h0A;
        regs[4*DW +: DW] = 5'h1F;
        bus.io_req_valid = 1'b0;
        bus.io_req_addr  = '0;
        bus.io_req_len   = '0;
        bus.io_rsp_ready = 1'b1;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check_idle("rst");
        check("rst.data", 32'(bus.io_rsp_data), 32'd0);
        check("rst.err",  32'(bus.io_rsp_err),  32'd0);
        check("rst.last", 32'(bus.io_rsp_last), 32'd0);

        // Single read of index 2
        request(3'd2, 2'd0);
        check_beat("single", 5'h15, 1'b0, 1'b1);
        check("single.busy",      32'(busy),             32'd1);
        check("single.req_ready", 32'(bus.io_req_ready), 32'd0);
        tick();
        check_idle("single.done");

        // Wrapping burst 6,7,0,1
        request(3'd6, 2'd3);
        check_beat("wrap.i6", 5'h00, 1'b1, 1'b0); tick();
        check_beat("wrap.i7", 5'h00, 1'b1, 1'b0); tick();
        check_beat("wrap.i0", 5'h11, 1'b0, 1'b0); tick();
        check_beat("wrap.i1", 5'h03, 1'b0, 1'b1); tick();
        check_idle("wrap.done");

        // Backpressure holds the first beat
        bus.io_rsp_ready = 1'b0;
        request(3'd0, 2'd1);
        for (int c = 0; c < 3; c++) begin
            check_beat("bp.hold", 5'h11, 1'b0, 1'b0);
            tick();
        end
        bus.io_rsp_ready = 1'b1;
        check_beat("bp.b0", 5'h11, 1'b0, 1'b0); tick();
        check_beat("bp.b1", 5'h03, 1'b0, 1'b1); tick();
        check_idle("bp.done");

        // Coherence: reg 4 changes after acceptance
        bus.io_rsp_ready = 1'b0;
        request(3'd3, 2'd1);
        regs[4*DW +: DW] = 5'h00;
        tick();
        bus.io_rsp_ready = 1'b1;
        check_beat("coh.b0", 5'h0A, 1'b0, 1'b0); tick();
        check_beat("coh.b1", 5'h1F, 1'b0, 1'b1); tick();
        check_idle("coh.done");
        regs[4*DW +: DW] = 5'h1F;

        // Reset mid-burst
        request(3'd0, 2'd3);
        check_beat("rmb.b0", 5'h11, 1'b0, 1'b0); tick();
        check_beat("rmb.b1", 5'h03, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check("rmb.rsp_valid", 32'(bus.io_rsp_valid), 32'd0);
        check("rmb.busy",      32'(busy),             32'd0);
        check("rmb.data",      32'(bus.io_rsp_data),  32'd0);
        reset = 1'b0;
        check("rmb.req_ready", 32'(bus.io_req_ready), 32'd1);
        request(3'd4, 2'd0);
        check_beat("rmb.new", 5'h1F, 1'b0, 1'b1); tick();
        check_idle("rmb.done");

        // Request gating with req_valid held high
        n_accepts = 0;
        bus.io_req_valid = 1'b1;
        bus.io_req_addr  = 3'd1;
        bus.io_req_len   = 2'd2;
        tick();
        check("gate.acc1", 32'(n_accepts), 32'd1);
        check_beat("gate.b0", 5'h03, 1'b0, 1'b0); tick();
        check_beat("gate.b1", 5'h15, 1'b0, 1'b0); tick();
        check_beat("gate.b2", 5'h0A, 1'b0, 1'b1); tick();
        check("gate.acc_hold", 32'(n_accepts), 32'd1);
        check_idle("gate.gap");
        bus.io_req_addr = 3'd4;
        bus.io_req_len  = 2'd0;
        tick();
        bus.io_req_valid = 1'b0;
        check("gate.acc2", 32'(n_accepts), 32'd2);
        check_beat("gate.next", 5'h1F, 1'b0, 1'b1); tick();
        check_idle("gate.done");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
